// File: rtl/motor_speed_ctrl_if.sv
// Signal bundle between the speed controller and its rpm source / motor driver.
interface motor_speed_ctrl_if;
    logic       enable;
    logic [7:0] target_rpm;
    logic [7:0] rpm;
    logic       rpm_valid;
    logic       fault_clr;
    logic       pwm;
    logic [7:0] duty;
    logic [1:0] state;
    logic       stall;

    modport master (
        output enable, target_rpm, rpm, rpm_valid, fault_clr,
        input  pwm, duty, state, stall
    );

    modport slave (
        input  enable, target_rpm, rpm, rpm_valid, fault_clr,
        output pwm, duty, state, stall
    );
endinterface

// File: rtl/motor_speed_ctrl.sv
// Closed-loop motor speed controller: soft-start ramp, deadband regulation,
// stall fault, and an 8-bit PWM whose duty is applied at period boundaries.
module motor_speed_ctrl #(
    parameter int unsigned RAMP_STEP     = 1,
    parameter int unsigned STEP_MAX      = 8,
    parameter int unsigned DEADBAND      = 2,
    parameter int unsigned STALL_DUTY    = 64,
    parameter int unsigned STALL_SAMPLES = 4
) (
    input  logic             cclk,
    input  logic             rst,
    motor_speed_ctrl_if.slave bus
);

    localparam int unsigned SCW = $clog2(STALL_SAMPLES + 1);
    localparam logic signed [8:0] DB_S   = 9'(DEADBAND);
    localparam logic signed [8:0] STEP_S = 9'(STEP_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RAMP  = 2'b01,
        RUN   = 2'b10,
        FAULT = 2'b11
    } state_t;

    state_t           st, st_nx;
    logic [7:0]       cnt;
    logic [7:0]       duty;
    logic [7:0]       duty_next, duty_next_nx;
    logic [SCW-1:0]   stall_cnt, stall_cnt_nx;
    logic             pwm_q;
    logic             force_zero;

    logic signed [8:0] err;
    logic signed [8:0] delta;
    logic signed [9:0] run_sum;
    logic [7:0]        run_sat;
    logic [8:0]        ramp_sum;
    logic [7:0]        ramp_sat;
    logic [7:0]        run_thresh;
    logic              in_band;
    logic              stall_hit;
    logic [SCW-1:0]    stall_inc;

    // Datapath for the per-sample duty update candidates
    always_comb begin
        err     = $signed({1'b0, bus.target_rpm}) - $signed({1'b0, bus.rpm});
        in_band = (err <= DB_S) && (err >= -DB_S);
        delta   = err >>> 1;
        if (delta > STEP_S)
            delta = STEP_S;
        else if (delta < -STEP_S)
            delta = -STEP_S;
        run_sum = $signed({2'b00, duty_next}) + $signed({delta[8], delta});
        if (run_sum < 10'sd0)
            run_sat = '0;
        else if (run_sum > 10'sd255)
            run_sat = '1;
        else
            run_sat = run_sum[7:0];

        ramp_sum = {1'b0, duty_next} + 9'(RAMP_STEP);
        ramp_sat = ramp_sum[8] ? '1 : ramp_sum[7:0];

        run_thresh = (bus.target_rpm > 8'(DEADBAND)) ? bus.target_rpm - 8'(DEADBAND) : '0;

        stall_hit = (bus.rpm == '0) && (duty >= 8'(STALL_DUTY));
        stall_inc = (stall_cnt >= SCW'(STALL_SAMPLES)) ? stall_cnt : stall_cnt + 1'b1;
    end

    always_comb begin
        st_nx        = st;
        duty_next_nx = duty_next;
        stall_cnt_nx = stall_cnt;
        unique case (st)
            IDLE: begin
                duty_next_nx = '0;
                stall_cnt_nx = '0;
                if (bus.enable && bus.target_rpm != '0)
                    st_nx = RAMP;
            end
            RAMP, RUN: begin
                if (!bus.enable || bus.target_rpm == '0) begin
                    st_nx        = IDLE;
                    duty_next_nx = '0;
                    stall_cnt_nx = '0;
                end else if (bus.rpm_valid) begin
                    stall_cnt_nx = stall_hit ? stall_inc : '0;
                    if (stall_cnt_nx == SCW'(STALL_SAMPLES)) begin
                        st_nx        = FAULT;
                        duty_next_nx = '0;
                    end else if (st == RAMP) begin
                        duty_next_nx = ramp_sat;
                        if (bus.rpm >= run_thresh)
                            st_nx = RUN;
                    end else if (!in_band) begin
                        duty_next_nx = run_sat;
                    end
                end
            end
            FAULT: begin
                duty_next_nx = '0;
                if (bus.fault_clr && !bus.enable) begin
                    st_nx        = IDLE;
                    stall_cnt_nx = '0;
                end
            end
        endcase
        force_zero = (st_nx == IDLE) || (st_nx == FAULT);
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            duty_next <= '0;
            stall_cnt <= '0;
        end else begin
            st        <= st_nx;
            duty_next <= duty_next_nx;
            stall_cnt <= stall_cnt_nx;
        end
    end

    // Disable and fault bypass the period boundary; otherwise duty takes the
    // pre-update duty_next on the last count of the period.
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            duty  <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt   <= (cnt == 8'd254) ? '0 : cnt + 8'd1;
            pwm_q <= (cnt < duty);
            if (force_zero)
                duty <= '0;
            else if (cnt == 8'd254)
                duty <= duty_next;
        end
    end

    assign bus.pwm   = pwm_q;
    assign bus.duty  = duty;
    assign bus.state = st;
    assign bus.stall = (st == FAULT);

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Self-checking bench for motor_speed_ctrl: directed scenarios plus a long
// randomized run against a cycle-level behavioural model.
module tb_motor_speed_ctrl;

    logic cclk = 1'b0;
    logic rst;

    motor_speed_ctrl_if bus ();

    motor_speed_ctrl #(
        .RAMP_STEP(1), .STEP_MAX(8), .DEADBAND(2), .STALL_DUTY(64), .STALL_SAMPLES(4)
    ) dut (
        .cclk(cclk),
        .rst (rst),
        .bus (bus)
    );

    always #5 cclk = ~cclk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: 0 IDLE, 1 RAMP, 2 RUN, 3 FAULT
    int ms, mdn, mduty, mcnt, msc, mpwm;

    function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
    function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

    task automatic model_reset();
        ms = 0; mdn = 0; mduty = 0; mcnt = 0; msc = 0; mpwm = 0;
    endtask

    task automatic model_step();
        int nst, ndn, nsc, nduty, err, d;
        if (rst) begin
            model_reset();
            return;
        end
        nst = ms; ndn = mdn; nsc = msc;
        if (ms == 0) begin
            ndn = 0; nsc = 0;
            if (bus.enable && bus.target_rpm != 0) nst = 1;
        end else if (ms == 3) begin
            ndn = 0;
            if (bus.fault_clr && !bus.enable) begin nst = 0; nsc = 0; end
        end else if (!bus.enable || bus.target_rpm == 0) begin
            nst = 0; ndn = 0; nsc = 0;
        end else if (bus.rpm_valid) begin
            nsc = (bus.rpm == 0 && mduty >= 64) ? imin(msc + 1, 4) : 0;
            if (nsc >= 4) begin
                nst = 3; ndn = 0;
            end else if (ms == 1) begin
                ndn = imin(mdn + 1, 255);
                if (int'(bus.rpm) >= imax(int'(bus.target_rpm) - 2, 0)) nst = 2;
            end else begin
                err = int'(bus.target_rpm) - int'(bus.rpm);
                if (err > 2 || err < -2) begin
                    d   = (err >= 0) ? err / 2 : -((1 - err) / 2);
                    d   = imax(imin(d, 8), -8);
                    ndn = imax(imin(mdn + d, 255), 0);
                end
            end
        end
        mpwm = (mcnt < mduty) ? 1 : 0;
        if (nst == 0 || nst == 3) nduty = 0;
        else if (mcnt == 254)     nduty = mdn;
        else                      nduty = mduty;
        mcnt = (mcnt + 1) % 255;
        ms = nst; mdn = ndn; msc = nsc; mduty = nduty;
    endtask

    task automatic cyc();
        model_step();
        @(posedge cclk);
        #1;
    endtask

    task automatic tick(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic sample(int v);
        bus.rpm_valid = 1'b1;
        bus.rpm       = 8'(v);
        cyc();
        bus.rpm_valid = 1'b0;
    endtask

    task automatic wait_boundary();
        do cyc(); while (mcnt != 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.enable = 1'b0; bus.target_rpm = '0; bus.rpm = '0;
        bus.rpm_valid = 1'b0; bus.fault_clr = 1'b0;
        model_reset();
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        checks++; if (bus.state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", bus.state); end
        checks++; if (bus.duty !== 8'd0) begin failures++; $display("FAIL reset_duty got=%0d exp=0", bus.duty); end
        checks++; if (bus.pwm !== 1'b0) begin failures++; $display("FAIL reset_pwm got=%b exp=0", bus.pwm); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
        checks++; if (dut.duty_next !== 8'd0) begin failures++; $display("FAIL reset_duty_next got=%0d exp=0", dut.duty_next); end
    endtask

    task automatic test_soft_start();
        bus.enable = 1'b1; bus.target_rpm = 8'd100;
        cyc();
        checks++; if (bus.state !== 2'b01) begin failures++; $display("FAIL ss_enter got=%b exp=01", bus.state); end
        for (int k = 0; k <= 10; k++) begin
            sample((k < 10) ? k * 10 : 98);
            checks++; if (dut.duty_next !== 8'(k + 1)) begin failures++; $display("FAIL ss_duty_next k=%0d got=%0d exp=%0d", k, dut.duty_next, k + 1); end
            checks++; if (bus.state !== ((k == 10) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL ss_state k=%0d got=%b", k, bus.state); end
            checks++; if (bus.duty !== 8'(mduty)) begin failures++; $display("FAIL ss_duty k=%0d got=%0d exp=%0d", k, bus.duty, mduty); end
            tick(299);
        end
    endtask

    task automatic test_run_regulation();
        for (int k = 0; k < 4; k++) sample(80);
        sample(86);
        checks++; if (dut.duty_next !== 8'd50) begin failures++; $display("FAIL run_setup got=%0d exp=50", dut.duty_next); end
        sample(80);
        checks++; if (dut.duty_next !== 8'd58) begin failures++; $display("FAIL run_clamp_up got=%0d exp=58", dut.duty_next); end
        sample(103);
        checks++; if (dut.duty_next !== 8'd56) begin failures++; $display("FAIL run_down got=%0d exp=56", dut.duty_next); end
        sample(99);
        checks++; if (dut.duty_next !== 8'd56) begin failures++; $display("FAIL run_deadband got=%0d exp=56", dut.duty_next); end
        checks++; if (bus.state !== 2'b10) begin failures++; $display("FAIL run_state got=%b exp=10", bus.state); end
    endtask

    task automatic test_period_boundary();
        int highs;
        sample(120); sample(120);
        wait_boundary();
        checks++; if (bus.duty !== 8'd40) begin failures++; $display("FAIL pb_duty40 got=%0d exp=40", bus.duty); end
        highs = 0;
        for (int i = 0; i < 255; i++) begin
            if (i == 100 || i == 101) begin bus.rpm_valid = 1'b1; bus.rpm = 8'd80; end
            else if (i == 102) begin bus.rpm_valid = 1'b1; bus.rpm = 8'd92; end
            else bus.rpm_valid = 1'b0;
            cyc();
            if (bus.pwm === 1'b1) highs++;
            if (i == 150) begin
                checks++; if (bus.duty !== 8'd40) begin failures++; $display("FAIL pb_mid_duty got=%0d exp=40", bus.duty); end
                checks++; if (dut.duty_next !== 8'd60) begin failures++; $display("FAIL pb_mid_next got=%0d exp=60", dut.duty_next); end
            end
        end
        checks++; if (highs != 40) begin failures++; $display("FAIL pb_highs40 got=%0d exp=40", highs); end
        checks++; if (bus.duty !== 8'd60) begin failures++; $display("FAIL pb_duty60 got=%0d exp=60", bus.duty); end
        highs = 0;
        for (int i = 0; i < 255; i++) begin
            cyc();
            if (bus.pwm === 1'b1) highs++;
        end
        checks++; if (highs != 60) begin failures++; $display("FAIL pb_highs60 got=%0d exp=60", highs); end
    endtask

    task automatic test_back_to_back();
        // Update landing on the last count of a period must not be applied yet
        while (mcnt != 254) cyc();
        sample(92);
        checks++; if (bus.duty !== 8'd60) begin failures++; $display("FAIL b2b_old_duty got=%0d exp=60", bus.duty); end
        checks++; if (dut.duty_next !== 8'd64) begin failures++; $display("FAIL b2b_new_next got=%0d exp=64", dut.duty_next); end
        wait_boundary();
        checks++; if (bus.duty !== 8'd64) begin failures++; $display("FAIL b2b_applied got=%0d exp=64", bus.duty); end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) sample(0);
        checks++; if (bus.state !== 2'b10) begin failures++; $display("FAIL stall_pre got=%b exp=10", bus.state); end
        sample(0);
        checks++; if (bus.state !== 2'b11) begin failures++; $display("FAIL stall_state got=%b exp=11", bus.state); end
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL stall_flag got=%b exp=1", bus.stall); end
        checks++; if (bus.duty !== 8'd0) begin failures++; $display("FAIL stall_duty got=%0d exp=0", bus.duty); end
        cyc();
        checks++; if (bus.pwm !== 1'b0) begin failures++; $display("FAIL stall_pwm got=%b exp=0", bus.pwm); end
        bus.fault_clr = 1'b1;
        tick(5);
        checks++; if (bus.state !== 2'b11) begin failures++; $display("FAIL stall_clr_ignored got=%b exp=11", bus.state); end
        bus.enable = 1'b0;
        cyc();
        checks++; if (bus.state !== 2'b00) begin failures++; $display("FAIL stall_clr_state got=%b exp=00", bus.state); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL stall_clr_flag got=%b exp=0", bus.stall); end
        bus.fault_clr = 1'b0;
    endtask

    task automatic test_disable_sample();
        bus.enable = 1'b1; bus.target_rpm = 8'd200;
        cyc();
        for (int k = 0; k < 69; k++) sample(50);
        sample(198);
        wait_boundary();
        checks++; if (bus.duty !== 8'd70) begin failures++; $display("FAIL ds_duty got=%0d exp=70", bus.duty); end
        for (int k = 0; k < 3; k++) sample(0);
        checks++; if (dut.stall_cnt !== 3'd3) begin failures++; $display("FAIL ds_stall_cnt got=%0d exp=3", dut.stall_cnt); end
        bus.enable = 1'b0;
        sample(0);
        checks++; if (bus.state !== 2'b00) begin failures++; $display("FAIL ds_state got=%b exp=00", bus.state); end
        checks++; if (bus.duty !== 8'd0) begin failures++; $display("FAIL ds_duty0 got=%0d exp=0", bus.duty); end
        cyc();
        checks++; if (bus.pwm !== 1'b0) begin failures++; $display("FAIL ds_pwm got=%b exp=0", bus.pwm); end
    endtask

    task automatic test_saturation();
        int highs;
        bus.enable = 1'b1; bus.target_rpm = 8'd255;
        cyc();
        for (int k = 0; k < 260; k++) sample(1);
        checks++; if (dut.duty_next !== 8'd255) begin failures++; $display("FAIL sat_next got=%0d exp=255", dut.duty_next); end
        wait_boundary();
        highs = 0;
        for (int i = 0; i < 255; i++) begin
            cyc();
            if (bus.pwm === 1'b1) highs++;
        end
        checks++; if (highs != 255) begin failures++; $display("FAIL sat_highs got=%0d exp=255", highs); end
        bus.enable = 1'b0;
        cyc();
        checks++; if (bus.duty !== 8'd0) begin failures++; $display("FAIL sat_force_duty got=%0d exp=0", bus.duty); end
        checks++; if (bus.pwm !== 1'b1) begin failures++; $display("FAIL sat_pwm_lag got=%b exp=1", bus.pwm); end
        cyc();
        checks++; if (bus.pwm !== 1'b0) begin failures++; $display("FAIL sat_pwm0 got=%b exp=0", bus.pwm); end
    endtask

    task automatic test_reset_mid_run();
        bus.enable = 1'b1; bus.target_rpm = 8'd200;
        cyc();
        for (int k = 0; k < 119; k++) sample(50);
        sample(198);
        wait_boundary();
        checks++; if (bus.duty !== 8'd120) begin failures++; $display("FAIL rmr_duty got=%0d exp=120", bus.duty); end
        tick(10);
        #2;
        rst = 1'b1;
        bus.enable = 1'b0;
        #1;
        model_reset();
        checks++; if (bus.pwm !== 1'b0 || bus.duty !== 8'd0 || bus.stall !== 1'b0 || bus.state !== 2'b00)
            begin failures++; $display("FAIL rmr_async pwm=%b duty=%0d stall=%b state=%b exp all 0", bus.pwm, bus.duty, bus.stall, bus.state); end
        cyc();
        rst = 1'b0;
        tick(20);
        checks++; if (bus.pwm !== 1'b0 || bus.duty !== 8'd0 || bus.stall !== 1'b0 || bus.state !== 2'b00)
            begin failures++; $display("FAIL rmr_after pwm=%b duty=%0d stall=%b state=%b exp all 0", bus.pwm, bus.duty, bus.stall, bus.state); end
    endtask

    task automatic test_random();
        int zero_burst = 0;
        bus.enable = 1'b1; bus.target_rpm = 8'd150;
        for (int n = 0; n < 15000; n++) begin
            rst = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 299) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 599) == 0) bus.target_rpm = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            bus.fault_clr = ($urandom_range(0, 19) == 0);
            bus.rpm_valid = ($urandom_range(0, 3) == 0);
            if (zero_burst == 0 && $urandom_range(0, 99) == 0) zero_burst = 8;
            if (zero_burst > 0) begin
                bus.rpm = '0;
                if (bus.rpm_valid) zero_burst--;
            end else begin
                bus.rpm = 8'(imax(imin(int'(bus.target_rpm) + $urandom_range(0, 40) - 20, 255), 0));
            end
            cyc();
            checks++; if (bus.state !== 2'(ms)) begin failures++; $display("FAIL rnd_state n=%0d got=%b exp=%0d", n, bus.state, ms); end
            checks++; if (bus.duty !== 8'(mduty)) begin failures++; $display("FAIL rnd_duty n=%0d got=%0d exp=%0d", n, bus.duty, mduty); end
            checks++; if (bus.pwm !== 1'(mpwm)) begin failures++; $display("FAIL rnd_pwm n=%0d got=%b exp=%0d", n, bus.pwm, mpwm); end
            checks++; if (bus.stall !== (ms == 3)) begin failures++; $display("FAIL rnd_stall n=%0d got=%b exp=%0d", n, bus.stall, ms == 3); end
        end
        rst = 1'b0;
        bus.rpm_valid = 1'b0;
        bus.fault_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_soft_start();
        test_run_regulation();
        test_period_boundary();
        test_back_to_back();
        test_stall();
        test_disable_sample();
        test_saturation();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
